pipeline_ctrl_sequencer: RTL
============================

// Module: pipeline_ctrl_sequencer
// PURPOSE
//  Central stall/flush sequencer for the 5-stage pipeline. Merges load-use stall, EX-stage
//  redirect, multi-cycle data-memory wait, instruction-fetch wait and a debug halt/resume
//  handshake into per-stage enable/flush strobes. Also runs a drain FSM and a memory-timeout watchdog.
// PARAMETERS
//  MEM_TIMEOUT_CYCLES  255  consecutive freeze cycles before error; 0 = watchdog disabled
//  DRAIN_DEPTH         4    advancing cycles needed to empty ID..WB
//  CNT_W               32   perf counter width (PIPE_PERF_CNT_EN only)
// PORTS
//  clk                 in   1      core clock
//  rst_n               in   1      asynchronous active-low reset
//  hz_stall            in   1      load-use stall request from hazard logic
//  ex_branch_taken     in   1      taken branch/jump resolved in EX
//  mem_req             in   1      MEM stage holds a load/store
//  mem_ready           in   1      data memory completes access this cycle
//  imem_ready          in   1      fetch data valid this cycle
//  halt_req            in   1      debug halt request (level)
//  resume_req          in   1      debug resume (pulse)
//  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en   out 1 each  stage register enables
//  if_id_flush, id_ex_flush  out 1 each  load NOP on next edge (flush beats enable)
//  mem_wb_bubble       out  1      MEM/WB loads NOP
//  halted              out  1      pipeline empty and stopped
//  err_timeout         out  1      sticky memory-timeout error
//  perf_stall_cnt, perf_flush_cnt, perf_memwait_cnt  out CNT_W each  perf counters
// BEHAVIOUR
//  - Reset: async to RUN; drain/timeout counters 0; halted=0, err_timeout=0, perf=0.
//    While rst_n=0: all *_en=0; if_id_flush, id_ex_flush, mem_wb_bubble=1.
//  - FSM states: RUN, MEM_WAIT, DRAIN, HALTED, ERROR.
//  - freeze = mem_req & ~mem_ready.
//  - Outputs, combinational, first match wins:
//    1. HALTED/ERROR: all *_en=0, flushes=0, mem_wb_bubble=0.
//    2. freeze: pc/if_id/id_ex/ex_mem_en=0; mem_wb_en=1 with mem_wb_bubble=1.
//    3. ex_branch_taken: all en=1; if_id_flush=id_ex_flush=1 (overrides hz_stall).
//    4. hz_stall: pc_en=if_id_en=0; id_ex_flush=1; rest en=1.
//    5. DRAIN or ~imem_ready: pc_en=0; if_id_flush=1; rest en=1.
//    6. Otherwise: all en=1, no flush.
//  - In DRAIN, a redirect still sets pc_en=1 so the target is captured. Fetch stays off.
//  - RUN: freeze -> MEM_WAIT. Otherwise halt_req -> DRAIN with drain_cnt=DRAIN_DEPTH.
//  - MEM_WAIT: mem_ready -> RUN. Halt is accepted only from RUN, never mid-access.
//  - Timeout: wait_cnt counts consecutive freeze cycles and clears on any non-freeze cycle.
//    When wait_cnt reaches MEM_TIMEOUT_CYCLES: -> ERROR, err_timeout=1.
//    ERROR exits only via rst_n.
//  - DRAIN: drain_cnt decrements on cycles that are neither freeze nor hz_stall.
//    At 1->0: -> HALTED. A freeze in DRAIN stays in DRAIN and the watchdog still runs.
//  - HALTED: halted=1. resume_req & ~halt_req -> RUN. resume_req while halt_req=1 is ignored.
//  - Simultaneous freeze + redirect: freeze wins. The branch stays in EX and redirects after release.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: three saturating counters (hold at all-ones), increment per cycle:
//    stall   = rule 4 active
//    flush   = rule 3 active
//    memwait = rule 2 active
//  Undefined: perf_* outputs tied 0 and no counter flops.
// STRUCTURE
//  pipe_ctrl_pkg: pipe_ctrl_state_e enum, DRAIN_DEPTH default, stage-strobe struct typedef.
//  Sub-module pipe_perf_counter (CNT_W, inc, saturating), instanced 3x under PIPE_PERF_CNT_EN.
// TESTING
//  1. hz_stall=1 for 1 cycle -> pc_en=if_id_en=0, id_ex_flush=1 that cycle; all en=1 next cycle.
//  2. mem_req=1, mem_ready=0 for 3 cycles, then 1 -> 3 frozen cycles with mem_wb_bubble=1;
//     RUN after; perf_memwait_cnt=3.
//  3. ex_branch_taken=1 with hz_stall=1 -> pc_en=1, if_id_flush=id_ex_flush=1, if_id_en=1.
//  4. halt_req=1 in RUN -> DRAIN with pc_en=0, halted=1 after 4 cycles (5 with one hz_stall);
//     halt_req=0 + resume_req -> RUN, pc_en=1.
//  5. MEM_TIMEOUT_CYCLES=8, mem_ready held 0 -> err_timeout=1 after 8th freeze cycle,
//     stays 1 after mem_ready=1 until rst_n.
//  6. rst_n low mid-DRAIN (drain_cnt=2) -> async RUN, halted=0, all en=0 during reset,
//     normal flow after release.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM state encoding,
// default drain depth and the packed per-stage strobe bundle.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        PS_RUN      = 3'd0,
        PS_MEM_WAIT = 3'd1,
        PS_DRAIN    = 3'd2,
        PS_HALTED   = 3'd3,
        PS_ERROR    = 3'd4
    } pipe_ctrl_state_e;

    localparam int PIPE_DRAIN_DEPTH_DEF = 4;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } stage_strobe_t;

endpackage

// File: rtl/pipe_perf_counter.sv
// Saturating event counter: counts cycles with inc=1 and holds at all-ones.
module pipe_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_ctrl_sequencer.sv
// Central stall/flush sequencer with drain/halt FSM and memory-timeout watchdog.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipeline_ctrl_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT_CYCLES = 255,
    parameter int DRAIN_DEPTH        = PIPE_DRAIN_DEPTH_DEF,
    parameter int CNT_W              = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hz_stall,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             imem_ready,
    input  logic             halt_req,
    input  logic             resume_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             halted,
    output logic             err_timeout,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt,
    output logic [CNT_W-1:0] perf_memwait_cnt
);

    localparam logic [2:0] ST_RUN      = PS_RUN;
    localparam logic [2:0] ST_MEM_WAIT = PS_MEM_WAIT;
    localparam logic [2:0] ST_DRAIN    = PS_DRAIN;
    localparam logic [2:0] ST_HALTED   = PS_HALTED;
    localparam logic [2:0] ST_ERROR    = PS_ERROR;

    localparam int  DRAIN_W    = $clog2(DRAIN_DEPTH + 1);
    localparam int  WAIT_W     = (MEM_TIMEOUT_CYCLES > 1) ? $clog2(MEM_TIMEOUT_CYCLES) : 1;
    localparam bit  TIMEOUT_EN = (MEM_TIMEOUT_CYCLES != 0);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT_CYCLES - 1);

    logic [2:0]         state;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               freeze;
    logic               stopped;
    logic               watch_en;
    logic               timeout_hit;
    stage_strobe_t      strobe;

    assign freeze      = mem_req & ~mem_ready;
    assign stopped     = (state == ST_HALTED) || (state == ST_ERROR);
    assign watch_en    = (state == ST_RUN) || (state == ST_MEM_WAIT) || (state == ST_DRAIN);
    assign timeout_hit = TIMEOUT_EN && watch_en && freeze && (wait_cnt == WAIT_LAST);
    assign halted      = (state == ST_HALTED);

    // Priority-ordered strobe selection; reset forces NOPs into every stage.
    always_comb begin
        strobe = '0;
        if (!rst_n) begin
            strobe.if_id_flush   = 1'b1;
            strobe.id_ex_flush   = 1'b1;
            strobe.mem_wb_bubble = 1'b1;
        end else if (stopped) begin
            strobe = '0;
        end else if (freeze) begin
            strobe.mem_wb_en     = 1'b1;
            strobe.mem_wb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            strobe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        end else if (hz_stall) begin
            strobe.id_ex_en    = 1'b1;
            strobe.ex_mem_en   = 1'b1;
            strobe.mem_wb_en   = 1'b1;
            strobe.id_ex_flush = 1'b1;
        end else if ((state == ST_DRAIN) || !imem_ready) begin
            strobe = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        end else begin
            strobe = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        end
    end

    assign pc_en         = strobe.pc_en;
    assign if_id_en      = strobe.if_id_en;
    assign id_ex_en      = strobe.id_ex_en;
    assign ex_mem_en     = strobe.ex_mem_en;
    assign mem_wb_en     = strobe.mem_wb_en;
    assign if_id_flush   = strobe.if_id_flush;
    assign id_ex_flush   = strobe.id_ex_flush;
    assign mem_wb_bubble = strobe.mem_wb_bubble;

    // The watchdog overrides every transition; ERROR is left only through reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            drain_cnt   <= '0;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (TIMEOUT_EN && watch_en && freeze && !timeout_hit) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (timeout_hit) begin
                state       <= ST_ERROR;
                err_timeout <= 1'b1;
            end else begin
                case (state)
                    ST_RUN: begin
                        if (freeze) begin
                            state <= ST_MEM_WAIT;
                        end else if (halt_req) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= DRAIN_W'(DRAIN_DEPTH);
                        end
                    end
                    ST_MEM_WAIT: begin
                        if (!freeze) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_DRAIN: begin
                        if (!freeze && !hz_stall) begin
                            drain_cnt <= drain_cnt - 1'b1;
                            if (drain_cnt == DRAIN_W'(1)) begin
                                state <= ST_HALTED;
                            end
                        end
                    end
                    ST_HALTED: begin
                        if (resume_req && !halt_req) begin
                            state <= ST_RUN;
                        end
                    end
                    ST_ERROR: begin
                        state <= ST_ERROR;
                    end
                    default: begin
                        state <= ST_RUN;
                    end
                endcase
            end
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic rule_memwait;
    logic rule_flush;
    logic rule_stall;

    assign rule_memwait = !stopped && freeze;
    assign rule_flush   = !stopped && !freeze && ex_branch_taken;
    assign rule_stall   = !stopped && !freeze && !ex_branch_taken && hz_stall;

    pipe_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rule_stall),
        .count (perf_stall_cnt)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rule_flush),
        .count (perf_flush_cnt)
    );

    pipe_perf_counter #(.CNT_W(CNT_W)) u_memwait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rule_memwait),
        .count (perf_memwait_cnt)
    );
`else
    assign perf_stall_cnt   = '0;
    assign perf_flush_cnt   = '0;
    assign perf_memwait_cnt = '0;
`endif

endmodule
